regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 92 +++++++++
 tb/tb_regfile_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write-port arbiter with a registered write
// stage, round-robin priority, same-cycle forwarding hits and a commit counter.
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        a_valid,
  input  logic [2:0]  a_addr,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [2:0]  b_addr,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic [2:0]  q_addr1,
  input  logic [2:0]  q_addr2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [15:0] fwd_data,
  output logic [7:0]  wr_count
);

  logic        prio_q, prio_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [7:0]  wr_count_q, wr_count_d;

  logic        grant;
  logic        commit;
  logic [2:0]  g_addr;
  logic [15:0] g_data;

  // prio_q=0 favours A under contention, prio_q=1 favours B
  always_comb begin
    a_ready = rst_n & ~hold & a_valid
            & (~b_valid | ~prio_q);
    b_ready = rst_n & ~hold & b_valid
            & ~a_ready;
    grant   = a_ready | b_ready;
    g_addr  = a_ready ? a_addr : b_addr;
    g_data  = a_ready ? a_data : b_data;
    commit  = grant && (g_addr != 3'd0);
  end

  always_comb begin
    prio_d     = prio_q;
    wr_en_d    = commit;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q + {7'd0, wr_en_q};
    if (a_ready) prio_d = 1'b1;
    if (b_ready) prio_d = 1'b0;
    // R0 writes are accepted but never reach the port
    if (commit) begin
      wr_addr_d = g_addr;
      wr_data_d = g_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 3'd0;
      wr_data_q  <= 16'd0;
      wr_count_q <= 8'd0;
    end else begin
      prio_q     <= prio_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    wr_en    = wr_en_q;
    wr_addr  = wr_addr_q;
    wr_data  = wr_data_q;
    wr_count = wr_count_q;
    fwd_data = wr_data_q;
    fwd1_hit = wr_en_q && (wr_addr_q != 3'd0)
            && (wr_addr_q == q_addr1);
    fwd2_hit = wr_en_q && (wr_addr_q != 3'd0)
            && (wr_addr_q == q_addr2);
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: stimulus pushes expected commits into a queue,
// a negedge monitor pops and compares every write-port strobe.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        a_valid, b_valid;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  q_addr1, q_addr2;
  logic        fwd1_hit, fwd2_hit;
  logic [15:0] fwd_data;
  logic [7:0]  wr_count;

  int total = 0;
  int bad = 0;
  logic [18:0] exp_q[$];
  logic [7:0]  exp_cnt = 8'd0;
  logic        mon_on = 1'b0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr),
    .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr),
    .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd_data(fwd_data), .wr_count(wr_count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // monitor: write-port strobes and the commit counter
  always @(negedge clk) begin
    if (mon_on) begin
      logic [18:0] e;
      chk("wr_count", {24'd0, wr_count},
          {24'd0, exp_cnt});
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious wr_en", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {29'd0, wr_addr},
              {29'd0, e[18:16]});
          chk("wr_data", {16'd0, wr_data},
              {16'd0, e[15:0]});
        end
      end
      if (!rst_n) exp_cnt = 8'd0;
      else if (wr_en === 1'b1) exp_cnt = exp_cnt + 8'd1;
    end
  end

  task automatic idle_in();
    hold = 1'b0;
    a_valid = 1'b0; a_addr = 3'd0; a_data = 16'd0;
    b_valid = 1'b0; b_addr = 3'd0; b_data = 16'd0;
    q_addr1 = 3'd0; q_addr2 = 3'd0;
  endtask

  // one cycle: drive, check readies, record expected commit
  task automatic cyc(input logic h,
                     input logic av,
                     input logic [2:0] aa,
                     input logic [15:0] ad,
                     input logic bv,
                     input logic [2:0] ba,
                     input logic [15:0] bd,
                     input logic ea,
                     input logic eb);
    @(posedge clk);
    #1;
    hold = h;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    chk("a_ready", {31'd0, a_ready}, {31'd0, ea});
    chk("b_ready", {31'd0, b_ready}, {31'd0, eb});
    if (ea && aa != 3'd0) exp_q.push_back({aa, ad});
    if (eb && ba != 3'd0) exp_q.push_back({ba, bd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle_in();
    rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 3'd7;
    b_valid = 1'b1; b_addr = 3'd6;
    #1;
    chk("rst a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk);
    #1;
    idle_in();
    chk("rst wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst wr_addr", {29'd0, wr_addr}, 32'd0);
    chk("rst wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst wr_count", {24'd0, wr_count}, 32'd0);
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    mon_on = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    do_reset();

    // single A write
    cyc(0, 1, 3, 16'h1234, 0, 0, 0, 1, 0);
    idle(1);
    #1 chk("cnt after one", {24'd0, wr_count}, 32'd0);
    idle(1);
    #1 chk("cnt one", {24'd0, wr_count}, 32'd1);

    // contention right after reset: A then B
    do_reset();
    cyc(0, 1, 2, 16'hAAAA, 1, 5, 16'h5555, 1, 0);
    cyc(0, 1, 2, 16'hAAAA, 1, 5, 16'h5555, 0, 1);
    idle(2);

    // R0 write by B flips prio back to A
    cyc(0, 1, 1, 16'h0101, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 1);
    idle(1);
    #1 chk("r0 no wr_en", {31'd0, wr_en}, 32'd0);
    chk("r0 wr_addr hold", {29'd0, wr_addr}, 32'd1);
    chk("r0 wr_data hold", {16'd0, wr_data},
        32'h0101);
    cyc(0, 1, 3, 16'h3333, 1, 4, 16'h4444, 1, 0);
    cyc(0, 0, 0, 0, 1, 4, 16'h4444, 0, 1);
    idle(2);

    // forwarding
    cyc(0, 1, 4, 16'h00F0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    idle_in();
    q_addr1 = 3'd4; q_addr2 = 3'd6;
    #1;
    chk("fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
    chk("fwd2_hit", {31'd0, fwd2_hit}, 32'd0);
    chk("fwd_data", {16'd0, fwd_data}, 32'h00F0);
    @(posedge clk);
    #1;
    q_addr1 = 3'd4; q_addr2 = 3'd0;
    #1;
    chk("fwd1 idle", {31'd0, fwd1_hit}, 32'd0);
    chk("fwd2 q0", {31'd0, fwd2_hit}, 32'd0);

    // grant then hold: pending write still commits
    cyc(0, 1, 5, 16'h0505, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 2, 16'h2222, 1, 3, 16'h3333, 0, 0);
    idle(1);
    #1 chk("hold wr_en", {31'd0, wr_en}, 32'd0);

    // grant A then reset: prio back to A afterwards
    cyc(0, 1, 6, 16'h0BEE, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    idle_in();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid rst wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid rst cnt", {24'd0, wr_count}, 32'd0);
    cyc(0, 1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0);
    cyc(0, 0, 0, 0, 1, 2, 16'h2222, 0, 1);
    idle(2);

    // counter wrap after 256 commits
    do_reset();
    for (int i = 0; i < 256; i++)
      cyc(0, 1, 1, i[15:0], 0, 0, 0, 1, 0);
    idle(2);
    #1 chk("cnt wrap", {24'd0, wr_count}, 32'd0);

    // same address, prio=1 after A grants: B first
    cyc(0, 1, 7, 16'hA7A7, 1, 7, 16'hB7B7, 0, 1);
    cyc(0, 1, 7, 16'hA7A7, 0, 0, 0, 1, 0);
    idle(1);
    idle(2);
    #1 chk("final data", {16'd0, wr_data}, 32'hA7A7);
    chk("queue drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
